// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// widths, FUNCT3 encodings, FSM state type and the divide-by-zero quotient.
package muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FIX    = 2'd2,
        DONE_S = 2'd3
    } md_state_t;

    // Quotient returned for any divide by zero.
    localparam logic [MD_XLEN-1:0] MD_DZ_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry/borrow out.
// Shared by the multiply (add) and divide (trial subtract) iterations.
module muldiv_addsub #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // One extra bit on the operands exposes the carry (add) or borrow (sub).
    always_comb begin
        if (i_sub) begin
            {o_cout, o_sum} = {1'b0, i_a} - {1'b0, i_b};
        end else begin
            {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};
        end
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide/remainder sequencer.
// Operands are captured as magnitudes, iterated over XLEN cycles
// (shift-add multiply, restoring divide), sign-corrected, then DONE pulses.
// Optional build macro MULDIV_ZERO_BYPASS_EN: multiplies with a zero
// operand skip the iteration loop.
module alu_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_data1,
    input  logic [XLEN-1:0] i_data2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    md_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_dz;
    logic [XLEN-1:0]   r_b;      // multiplicand / divisor magnitude
    logic [XLEN-1:0]   r_acc;    // product high half / partial remainder
    logic [XLEN-1:0]   r_q;      // multiplier->product low / dividend->quotient
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_div_zero;
    logic              w_skip_mul;
    logic              w_neg_init;
    logic [XLEN-1:0]   w_b_init;
    logic [XLEN-1:0]   w_q_init;
    md_state_t         w_state_init;

    logic              w_is_div;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic [XLEN:0]     w_sum;
    logic              w_cout;

    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quot_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_fix_result;

`ifdef MULDIV_ZERO_BYPASS_EN
    assign w_skip_mul = !i_funct3[2] && ((i_data1 == '0) || (i_data2 == '0));
`else
    assign w_skip_mul = 1'b0;
`endif

    assign w_div_zero = i_funct3[2] && (i_data2 == '0);

    // Operand magnitudes, result sign and entry state for an accepted request.
    always_comb begin
        w_neg1 = 1'b0;
        w_neg2 = 1'b0;
        unique case (i_funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                w_neg1 = i_data1[XLEN-1];
                w_neg2 = i_data2[XLEN-1];
            end
            F3_MULHSU: w_neg1 = i_data1[XLEN-1];
            default: ;
        endcase
        w_mag1 = w_neg1 ? ('0 - i_data1) : i_data1;
        w_mag2 = w_neg2 ? ('0 - i_data2) : i_data2;
        // Remainder follows the dividend; everything else is the sign XOR
        // (w_neg2 is already 0 for MULHSU and the unsigned ops).
        w_neg_init = (i_funct3 == F3_REM) ? w_neg1 : (w_neg1 ^ w_neg2);
        w_b_init   = i_funct3[2] ? w_mag2 : w_mag1;
        w_q_init   = i_funct3[2] ? w_mag1 : w_mag2;
        w_state_init = CALC;
        if (w_div_zero) begin
            // Raw dividend kept so REM/REMU can return it unchanged.
            w_neg_init   = 1'b0;
            w_q_init     = i_data1;
            w_state_init = FIX;
        end else if (w_skip_mul) begin
            w_q_init     = '0;
            w_state_init = FIX;
        end
    end

    // Operand routing into the shared adder for one iteration.
    always_comb begin
        w_is_div = r_op[2];
        if (w_is_div) begin
            w_add_a = {r_acc, r_q[XLEN-1]};
            w_add_b = {1'b0, r_b};
        end else begin
            w_add_a = {1'b0, r_acc};
            w_add_b = r_q[0] ? {1'b0, r_b} : '0;
        end
    end

    muldiv_addsub #(
        .WIDTH(XLEN + 1)
    ) u_addsub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_sub  (w_is_div),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Sign correction and half/quotient/remainder selection.
    always_comb begin
        w_prod   = {r_acc, r_q};
        w_prod_s = r_neg ? ('0 - w_prod) : w_prod;
        w_quot_s = r_neg ? ('0 - r_q) : r_q;
        w_rem_s  = r_neg ? ('0 - r_acc) : r_acc;
        unique case (r_op)
            F3_MUL:                      w_fix_result = w_prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             w_fix_result = r_dz ? MD_DZ_QUOTIENT : w_quot_s;
            default:                     w_fix_result = r_dz ? r_q : w_rem_s;
        endcase
    end

    // Sequencer FSM with registered BUSY/DONE/RESULT.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= F3_MUL;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start && !i_flush) begin
                        r_op    <= i_funct3;
                        r_neg   <= w_neg_init;
                        r_dz    <= w_div_zero;
                        r_b     <= w_b_init;
                        r_q     <= w_q_init;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= w_state_init;
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        if (w_is_div) begin
                            // Restoring step: keep the difference only without borrow.
                            r_acc <= w_cout ? w_add_a[XLEN-1:0] : w_sum[XLEN-1:0];
                            r_q   <= {r_q[XLEN-2:0], ~w_cout};
                        end else begin
                            // Shift-add: the sum and multiplier shift right together.
                            r_acc <= w_sum[XLEN:1];
                            r_q   <= {w_sum[0], r_q[XLEN-1:1]};
                        end
                        if (r_cnt == CNT_W'(XLEN - 1)) begin
                            r_cnt   <= '0;
                            r_state <= FIX;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (i_flush) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_result <= w_fix_result;
                        r_done   <= 1'b1;
                        r_state  <= DONE_S;
                    end
                end
                DONE_S: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer: directed cases plus
// randomized operations against an arithmetic reference model.
// Honors MULDIV_ZERO_BYPASS_EN for the expected multiply latency.
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [2:0]  i_funct3;
    logic [31:0] i_data1;
    logic [31:0] i_data2;
    logic        i_flush;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result = '0;

    alu_muldiv_sequencer #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_funct3 (i_funct3),
        .i_data1  (i_data1),
        .i_data2  (i_data2),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RV32M semantics computed directly with 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; pu = ua / ub; return pu[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 2;
`ifdef MULDIV_ZERO_BYPASS_EN
        if (!f[2] && (a == 0 || b == 0)) return 2;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Issue one operation and check latency, BUSY span, RESULT and the
    // quiet cycles after DONE. With inject set, stray STARTs are driven
    // while busy and in the DONE cycle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit inject, output logic [31:0] res);
        int   lat;
        logic busy_ok;
        logic [31:0] exp_res;
        exp_res = ref_model(f, a, b);
        @(negedge clk);
        i_start = 1'b1; i_funct3 = f; i_data1 = a; i_data2 = b;
        @(negedge clk);
        i_start = 1'b0;
        i_funct3 = 3'($urandom()); i_data1 = $urandom(); i_data2 = $urandom();
        lat = 0;
        busy_ok = 1'b1;
        res = 'x;
        for (int j = 1; j <= 40 && lat == 0; j++) begin
            if (j > 1) @(negedge clk);
            i_start = 1'b0;
            if (!o_busy) busy_ok = 1'b0;
            if (o_done) begin
                lat = j;
                res = o_result;
                if (inject) i_start = 1'b1;
            end else if (inject && (j % 7 == 3)) begin
                i_start = 1'b1; i_funct3 = 3'($urandom()); i_data1 = $urandom(); i_data2 = $urandom();
            end
        end
        chk({tag, "/latency"}, 32'(lat), 32'(ref_latency(f, a, b)));
        chk({tag, "/busy_span"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "/result"}, res, exp_res);
        @(negedge clk);
        i_start = 1'b0;
        chk({tag, "/busy_after"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "/done_after"}, {31'd0, o_done}, 32'd0);
        @(negedge clk);
        chk({tag, "/not_restarted"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "/result_hold"}, o_result, exp_res);
        last_result = exp_res;
    endtask

    logic [31:0] r;
    logic        saw_done;

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0;
        i_funct3 = '0; i_data1 = '0; i_data2 = '0;
        repeat (3) @(negedge clk);
        chk("reset/busy", {31'd0, o_busy}, 32'd0);
        chk("reset/done", {31'd0, o_done}, 32'd0);
        chk("reset/result", o_result, 32'd0);
        i_reset = 1'b0;

        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, r);
        chk("mul_7_m3/plan", r, 32'hFFFF_FFEB);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, r);
        chk("mulh_min/plan", r, 32'h4000_0000);
        run_op("mulhsu_min", 3'd2, 32'h8000_0000, 32'h8000_0000, 1'b0, r);
        chk("mulhsu_min/plan", r, 32'hC000_0000);
        run_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, r);
        chk("mulhu_min/plan", r, 32'h4000_0000);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 1'b0, r);
        chk("divu_100_7/plan", r, 32'd14);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 1'b0, r);
        chk("remu_100_7/plan", r, 32'd2);
        run_op("div_m100_7", 3'd4, 32'hFFFF_FF9C, 32'd7, 1'b0, r);
        chk("div_m100_7/plan", r, 32'hFFFF_FFF2);
        run_op("rem_m100_7", 3'd6, 32'hFFFF_FF9C, 32'd7, 1'b0, r);
        chk("rem_m100_7/plan", r, 32'hFFFF_FFFE);
        run_op("div_5_0", 3'd4, 32'd5, 32'd0, 1'b0, r);
        chk("div_5_0/plan", r, 32'hFFFF_FFFF);
        run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 1'b0, r);
        chk("rem_5_0/plan", r, 32'd5);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
        chk("div_ovf/plan", r, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
        chk("rem_ovf/plan", r, 32'd0);
        run_op("mul_zero", 3'd0, 32'd0, 32'h1234, 1'b0, r);
        chk("mul_zero/plan", r, 32'd0);
        run_op("inject_start", 3'd5, 32'd1000, 32'd33, 1'b1, r);

        // FLUSH mid-operation: sampled at edge k+10, BUSY low at k+11.
        @(negedge clk);
        i_start = 1'b1; i_funct3 = 3'd1; i_data1 = 32'h1234_5678; i_data2 = 32'h9ABC_DEF0;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush/busy", {31'd0, o_busy}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_done || o_busy) saw_done = 1'b1;
        end
        chk("flush/no_done", {31'd0, saw_done}, 32'd0);
        chk("flush/result", o_result, last_result);

        // FLUSH and START together in IDLE: not accepted.
        i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0; i_data1 = 32'd3; i_data2 = 32'd4;
        @(negedge clk);
        i_start = 1'b0; i_flush = 1'b0;
        chk("flush_start/busy", {31'd0, o_busy}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_done || o_busy) saw_done = 1'b1;
        end
        chk("flush_start/no_done", {31'd0, saw_done}, 32'd0);

        // RESET mid-operation at edge k+20.
        i_start = 1'b1; i_funct3 = 3'd4; i_data1 = 32'd12345; i_data2 = 32'd67;
        @(negedge clk);
        i_start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_reset/busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("mid_reset/busy", {31'd0, o_busy}, 32'd0);
        chk("mid_reset/done", {31'd0, o_done}, 32'd0);
        chk("mid_reset/result", o_result, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_done || o_busy) saw_done = 1'b1;
        end
        chk("mid_reset/no_done", {31'd0, saw_done}, 32'd0);
        last_result = '0;

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            f = 3'($urandom_range(0, 7));
            a = rand_operand();
            b = rand_operand();
            run_op($sformatf("rand%0d_f%0d_%h_%h", n, f, a, b), f, a, b, 1'($urandom_range(0, 1)), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
